// File: rtl/wb_stage_param.sv
// wb_stage_param -- writeback stage of the 16-bit processor.
//
// Takes one retiring instruction per cycle and picks its result from one of
// four sources: ALU, memory, link address or immediate. Byte loads are pulled
// out of the selected lane and sign- or zero-extended. A two-state FSM waits
// when memory is slow. The stage drives a registered register-file write port
// and a wrapping retire counter.
//
// Ports
//   clock, reset        stage clock; asynchronous active-high reset
//   in_valid/in_ready   upstream handshake (in_ready is high only in IDLE)
//   flush               kills the instruction offered now or waiting in WAIT
//   in_wb_en, in_rd     register write enable and destination
//   in_wb_sel           0=ALU 1=MEM 2=LINK 3=IMM
//   in_alu/link/imm     non-memory result sources
//   in_mem_byte/sext/hi byte-load controls
//   mem_ready/mem_rdata memory read data, valid while mem_ready=1
//   rf_we/waddr/wdata   registered register-file write port
//   stall_out           ~in_ready
//   retired             count of completed instructions (wraps)
//   state_dbg           current FSM state (0=IDLE, 1=WAIT)
//
// Handshake: an instruction moves in on a rising clock edge when in_valid and
// in_ready are both high and flush is low. Upstream holds its in_* values
// while in_ready is low. in_ready depends only on the state register.
module wb_stage_param #(
    parameter int DATA_W   = 16,
    parameter int RADDR_W  = 3,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    input  logic               in_wb_en,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic [1:0]         in_wb_sel,
    input  logic [DATA_W-1:0]  in_alu,
    input  logic [DATA_W-1:0]  in_link,
    input  logic [DATA_W-1:0]  in_imm,
    input  logic               in_mem_byte,
    input  logic               in_mem_sext,
    input  logic               in_mem_hi,
    input  logic               mem_ready,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic               stall_out,
    output logic [CNT_W-1:0]   retired,
    output logic               state_dbg
);

    localparam logic [1:0] SEL_ALU  = 2'd0;
    localparam logic [1:0] SEL_MEM  = 2'd1;
    localparam logic [1:0] SEL_LINK = 2'd2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic                 rf_we_q, rf_we_d;
    logic [RADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]    rf_wdata_q, rf_wdata_d;
    logic [CNT_W-1:0]     retired_q, retired_d;
    // Fields of a load held in WAIT
    logic                 h_wb_en_q, h_wb_en_d;
    logic [RADDR_W-1:0]   h_rd_q, h_rd_d;
    logic                 h_byte_q, h_byte_d;
    logic                 h_sext_q, h_sext_d;
    logic                 h_hi_q, h_hi_d;

    logic                 accept;
    logic                 complete;
    logic                 c_wb_en;
    logic [RADDR_W-1:0]   c_rd;
    logic [DATA_W-1:0]    c_data;

    // The high lane is the top byte of the word, which is bits [15:8] when
    // DATA_W is 16. The extension fills the whole word first and then puts
    // the lane in [7:0], so DATA_W=8 needs no special case.
    function automatic logic [DATA_W-1:0] extract(
        input logic [DATA_W-1:0] rdata,
        input logic              is_byte,
        input logic              sext,
        input logic              hi
    );
        logic [7:0]        lane;
        logic [DATA_W-1:0] ext;
        lane     = hi ? rdata[DATA_W-1 -: 8] : rdata[7:0];
        ext      = {DATA_W{sext & lane[7]}};
        ext[7:0] = lane;
        return is_byte ? ext : rdata;
    endfunction

    assign in_ready  = (state_q == S_IDLE);
    assign stall_out = ~in_ready;
    assign accept    = in_valid & in_ready & ~flush;

    always_comb begin
        state_d   = state_q;
        h_wb_en_d = h_wb_en_q;
        h_rd_d    = h_rd_q;
        h_byte_d  = h_byte_q;
        h_sext_d  = h_sext_q;
        h_hi_d    = h_hi_q;
        complete  = 1'b0;
        c_wb_en   = in_wb_en;
        c_rd      = in_rd;
        c_data    = in_imm;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (in_wb_sel != SEL_MEM || mem_ready) begin
                        complete = 1'b1;
                        case (in_wb_sel)
                            SEL_ALU:  c_data = in_alu;
                            SEL_MEM:  c_data = extract(mem_rdata, in_mem_byte,
                                                       in_mem_sext, in_mem_hi);
                            SEL_LINK: c_data = in_link;
                            default:  c_data = in_imm;
                        endcase
                    end else begin
                        state_d   = S_WAIT;
                        h_wb_en_d = in_wb_en;
                        h_rd_d    = in_rd;
                        h_byte_d  = in_mem_byte;
                        h_sext_d  = in_mem_sext;
                        h_hi_d    = in_mem_hi;
                    end
                end
            end
            S_WAIT: begin
                // A flush takes priority over data arriving in the same cycle.
                if (flush) begin
                    state_d = S_IDLE;
                end else if (mem_ready) begin
                    state_d  = S_IDLE;
                    complete = 1'b1;
                    c_wb_en  = h_wb_en_q;
                    c_rd     = h_rd_q;
                    c_data   = extract(mem_rdata, h_byte_q, h_sext_q, h_hi_q);
                end
            end
            default: state_d = S_IDLE;
        endcase

        rf_we_d    = complete & c_wb_en & ~((ZERO_REG != 0) && (c_rd == '0));
        rf_waddr_d = rf_we_d ? c_rd : rf_waddr_q;
        rf_wdata_d = rf_we_d ? c_data : rf_wdata_q;
        // Every completion counts, including writes that are suppressed.
        retired_d  = retired_q + CNT_W'(complete);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            retired_q  <= '0;
            h_wb_en_q  <= 1'b0;
            h_rd_q     <= '0;
            h_byte_q   <= 1'b0;
            h_sext_q   <= 1'b0;
            h_hi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            retired_q  <= retired_d;
            h_wb_en_q  <= h_wb_en_d;
            h_rd_q     <= h_rd_d;
            h_byte_q   <= h_byte_d;
            h_sext_q   <= h_sext_d;
            h_hi_q     <= h_hi_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign retired   = retired_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_wb_stage_param.sv
module tb_wb_stage_param;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        flush;
    logic        in_wb_en;
    logic [2:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [15:0] in_alu;
    logic [15:0] in_link;
    logic [15:0] in_imm;
    logic        in_mem_byte;
    logic        in_mem_sext;
    logic        in_mem_hi;
    logic        mem_ready;
    logic [15:0] mem_rdata;

    logic        in_ready,  s_in_ready;
    logic        rf_we,     s_rf_we;
    logic [2:0]  rf_waddr,  s_rf_waddr;
    logic [15:0] rf_wdata,  s_rf_wdata;
    logic        stall_out, s_stall_out;
    logic [15:0] retired;
    logic [3:0]  s_retired;
    logic        state_dbg, s_state_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    wb_stage_param dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .in_wb_en(in_wb_en), .in_rd(in_rd), .in_wb_sel(in_wb_sel),
        .in_alu(in_alu), .in_link(in_link), .in_imm(in_imm),
        .in_mem_byte(in_mem_byte), .in_mem_sext(in_mem_sext), .in_mem_hi(in_mem_hi),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .stall_out(stall_out),
        .retired(retired), .state_dbg(state_dbg)
    );

    // Small-counter instance sharing the same stimulus, for the wrap test.
    wb_stage_param #(.CNT_W(4)) dut_small (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .flush(flush), .in_wb_en(in_wb_en), .in_rd(in_rd), .in_wb_sel(in_wb_sel),
        .in_alu(in_alu), .in_link(in_link), .in_imm(in_imm),
        .in_mem_byte(in_mem_byte), .in_mem_sext(in_mem_sext), .in_mem_hi(in_mem_hi),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .rf_we(s_rf_we),
        .rf_waddr(s_rf_waddr), .rf_wdata(s_rf_wdata), .stall_out(s_stall_out),
        .retired(s_retired), .state_dbg(s_state_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge; outputs are then sampled 1 time unit later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_port(input string tag, input logic we, input logic [2:0] wa,
                              input logic [15:0] wd, input logic [15:0] ret);
        check({tag, ".rf_we"}, 32'(rf_we), 32'(we));
        check({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(wa));
        check({tag, ".rf_wdata"}, 32'(rf_wdata), 32'(wd));
        check({tag, ".retired"}, 32'(retired), 32'(ret));
    endtask

    task automatic offer(input logic [1:0] sel, input logic [2:0] rd, input logic wb_en);
        in_valid  = 1'b1;
        in_wb_sel = sel;
        in_rd     = rd;
        in_wb_en  = wb_en;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; in_wb_en = 1'b0;
        in_rd = '0; in_wb_sel = '0; in_alu = '0; in_link = '0; in_imm = '0;
        in_mem_byte = 1'b0; in_mem_sext = 1'b0; in_mem_hi = 1'b0;
        mem_ready = 1'b0; mem_rdata = '0;

        // Reset state
        step(); step();
        check_port("reset", 1'b0, 3'd0, 16'h0000, 16'd0);
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check("reset.stall_out", 32'(stall_out), 32'd0);
        reset = 1'b0;

        // T1 ALU path
        offer(2'd0, 3'd3, 1'b1); in_alu = 16'h1234;
        step();
        check_port("t1", 1'b1, 3'd3, 16'h1234, 16'd1);
        in_valid = 1'b0; in_alu = 16'hDEAD;
        step();
        check_port("t1_hold", 1'b0, 3'd3, 16'h1234, 16'd1);

        // T2 signed high byte with three wait cycles
        offer(2'd1, 3'd5, 1'b1);
        in_mem_byte = 1'b1; in_mem_sext = 1'b1; in_mem_hi = 1'b1; mem_ready = 1'b0;
        step();
        check("t2_w1.in_ready", 32'(in_ready), 32'd0);
        check("t2_w1.stall_out", 32'(stall_out), 32'd1);
        check("t2_w1.rf_we", 32'(rf_we), 32'd0);
        // Change the live fields to confirm the latched ones are used.
        in_valid = 1'b0; in_mem_sext = 1'b0; in_mem_hi = 1'b0; in_rd = 3'd7;
        step();
        check("t2_w2.in_ready", 32'(in_ready), 32'd0);
        step();
        check("t2_w3.in_ready", 32'(in_ready), 32'd0);
        check("t2_w3.rf_we", 32'(rf_we), 32'd0);
        mem_ready = 1'b1; mem_rdata = 16'h80FF;
        step();
        check_port("t2_done", 1'b1, 3'd5, 16'hFF80, 16'd2);
        check("t2_done.in_ready", 32'(in_ready), 32'd1);
        mem_ready = 1'b0;
        step();
        check("t2_pulse_end.rf_we", 32'(rf_we), 32'd0);

        // T3 zero-extended low byte, immediate memory response
        offer(2'd1, 3'd2, 1'b1);
        in_mem_byte = 1'b1; in_mem_sext = 1'b0; in_mem_hi = 1'b0;
        mem_ready = 1'b1; mem_rdata = 16'h80FF;
        step();
        check_port("t3_zext", 1'b1, 3'd2, 16'h00FF, 16'd3);
        // Write to r0 is suppressed but still retires
        offer(2'd0, 3'd0, 1'b1); in_alu = 16'hBEEF; mem_ready = 1'b0;
        step();
        check_port("t3_r0", 1'b0, 3'd2, 16'h00FF, 16'd4);
        // Full-word load
        offer(2'd1, 3'd7, 1'b1); in_mem_byte = 1'b0;
        mem_ready = 1'b1; mem_rdata = 16'hA5C3;
        step();
        check_port("word_load", 1'b1, 3'd7, 16'hA5C3, 16'd5);
        // Signed low byte
        offer(2'd1, 3'd1, 1'b1);
        in_mem_byte = 1'b1; in_mem_sext = 1'b1; in_mem_hi = 1'b0; mem_rdata = 16'h1280;
        step();
        check_port("sext_lo", 1'b1, 3'd1, 16'hFF80, 16'd6);
        // Unsigned high byte
        offer(2'd1, 3'd4, 1'b1);
        in_mem_sext = 1'b0; in_mem_hi = 1'b1; mem_rdata = 16'h9A34;
        step();
        check_port("zext_hi", 1'b1, 3'd4, 16'h009A, 16'd7);
        in_valid = 1'b0; mem_ready = 1'b0;

        // T4 flush beats mem_ready in WAIT
        offer(2'd1, 3'd4, 1'b1); in_mem_byte = 1'b0;
        step();
        check("t4_wait.in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0; flush = 1'b1; mem_ready = 1'b1; mem_rdata = 16'h1111;
        step();
        check_port("t4_flush", 1'b0, 3'd4, 16'h009A, 16'd7);
        check("t4_flush.in_ready", 32'(in_ready), 32'd1);
        flush = 1'b0; mem_ready = 1'b0;
        step();
        check("t4_after.rf_we", 32'(rf_we), 32'd0);
        // Flush with in_valid in IDLE: nothing accepted
        offer(2'd0, 3'd6, 1'b1); in_alu = 16'h5555; flush = 1'b1;
        step();
        check_port("idle_flush", 1'b0, 3'd4, 16'h009A, 16'd7);
        flush = 1'b0; in_valid = 1'b0;
        step();
        check("idle_flush_after.rf_we", 32'(rf_we), 32'd0);

        // T5 back-to-back LINK then IMM
        offer(2'd2, 3'd1, 1'b1); in_link = 16'h0042;
        step();
        check_port("t5_link", 1'b1, 3'd1, 16'h0042, 16'd8);
        offer(2'd3, 3'd6, 1'b1); in_imm = 16'h7FFF;
        step();
        check_port("t5_imm", 1'b1, 3'd6, 16'h7FFF, 16'd9);
        in_valid = 1'b0;
        step();
        check("t5_end.rf_we", 32'(rf_we), 32'd0);

        // Reset in the middle of WAIT
        offer(2'd1, 3'd3, 1'b1); mem_ready = 1'b0;
        step();
        check("t5_wait.in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_port("t5_rst", 1'b0, 3'd0, 16'h0000, 16'd0);
        check("t5_rst.in_ready", 32'(in_ready), 32'd1);
        mem_ready = 1'b1; mem_rdata = 16'h4321;
        step();
        reset = 1'b0;
        step();
        check_port("t5_rst_release", 1'b0, 3'd0, 16'h0000, 16'd0);
        mem_ready = 1'b0;
        step();
        check("t5_rst_release2.rf_we", 32'(rf_we), 32'd0);

        // T6 counter wrap on the 4-bit instance: 17 completions -> 1
        check("t6_start.retired_small", 32'(s_retired), 32'd0);
        offer(2'd0, 3'd2, 1'b0);
        for (int i = 1; i <= 17; i++) begin
            step();
            if (i == 15) check("t6_15.retired_small", 32'(s_retired), 32'd15);
            if (i == 16) check("t6_16.retired_small", 32'(s_retired), 32'd0);
        end
        in_valid = 1'b0;
        check("t6_17.retired_small", 32'(s_retired), 32'd1);
        check("t6_17.retired_wide", 32'(retired), 32'd17);
        check("t6_17.rf_we_wb_en0", 32'(rf_we), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
